bt656_encoder: RTL

BT656_ENCODER -- requirements
Module: bt656_encoder

---
 rtl/bt656_encoder_if.sv | 19 +
 rtl/bt656_encoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bt656_encoder_if.sv
// Pixel stream handshake into the BT.656 encoder.
// The source drives 4:2:2 pixels; the encoder pulls one per C-byte slot.
interface bt656_encoder_if;
    logic [15:0] in_pixel;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output in_pixel,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_pixel,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/bt656_encoder.sv
// BT.656 byte-stream generator: EAV/SAV timing, 4:2:2 pixel insertion,
// active-low syncs, start-of-frame pulse and sticky underflow flag.
module bt656_encoder #(
    parameter int H_TOTAL   = 1716,
    parameter int V_TOTAL   = 525,
    parameter int F2_START  = 266,
    parameter int VA1_START = 20,
    parameter int VA1_END   = 263,
    parameter int VA2_START = 283,
    parameter int VA2_END   = 525,
    parameter int HS_LEN    = 128
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    bt656_encoder_if.slave pix,
    output logic [7:0]     td_data,
    output logic           td_hs,
    output logic           td_vs,
    output logic           field,
    output logic           sof,
    output logic           underflow,
    input  logic           underflow_clr
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int LW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] SAV_H  = HW'(H_TOTAL - 1444);
    localparam logic [HW-1:0] ACT_H  = HW'(H_TOTAL - 1440);
    localparam logic [HW-1:0] BLK_H  = HW'(4);
    localparam logic [HW-1:0] HS_H   = HW'(HS_LEN);

    localparam logic [LW-1:0] L_ONE  = LW'(1);
    localparam logic [LW-1:0] L_LAST = LW'(V_TOTAL);
    localparam logic [LW-1:0] L_F1E  = LW'(4);
    localparam logic [LW-1:0] L_F2   = LW'(F2_START);
    localparam logic [LW-1:0] L_VA1S = LW'(VA1_START);
    localparam logic [LW-1:0] L_VA1E = LW'(VA1_END);
    localparam logic [LW-1:0] L_VA2S = LW'(VA2_START);
    localparam logic [LW-1:0] L_VA2E = LW'(VA2_END);
    localparam logic [LW-1:0] L_VS1S = LW'(4);
    localparam logic [LW-1:0] L_VS1E = LW'(6);
    localparam logic [LW-1:0] L_VS2E = LW'(F2_START + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic [HW-1:0]   r_h;
    logic [LW-1:0]   r_line;
    logic [7:0]      r_yhold;
    logic [7:0]      r_td;
    logic            r_hs;
    logic            r_vs;
    logic            r_field;
    logic            r_sof;
    logic            r_uf;

    logic            w_run;
    logic            w_f;
    logic            w_v;
    logic            w_eav;
    logic            w_sav;
    logic            w_act;
    logic            w_apar;
    logic            w_bpar;
    logic [1:0]      w_sidx;
    logic [7:0]      w_xy;
    logic [7:0]      w_byte;
    logic            w_ready;
    logic            w_uf_set;
    logic            w_hlast;
    logic            w_last;
    logic            w_vsync;

    function automatic logic [7:0] clip(input logic [7:0] b);
        if (b == 8'h00)
            return 8'h01;
        else if (b == 8'hFF)
            return 8'hFE;
        else
            return b;
    endfunction

    assign w_run   = (r_state != S_IDLE);
    assign w_f     = (r_line < L_F1E) || (r_line >= L_F2);
    assign w_v     = !(((r_line >= L_VA1S) && (r_line <= L_VA1E)) ||
                       ((r_line >= L_VA2S) && (r_line <= L_VA2E)));
    assign w_eav   = (r_h < BLK_H);
    assign w_sav   = (r_h >= SAV_H) && (r_h < ACT_H);
    assign w_act   = (r_h >= ACT_H);
    assign w_apar  = r_h[0] ^ ACT_H[0];
    assign w_bpar  = r_h[0] ^ BLK_H[0];
    assign w_sidx  = w_eav ? r_h[1:0] : (r_h[1:0] - SAV_H[1:0]);
    assign w_xy    = {1'b1, w_f, w_v, w_eav, w_v ^ w_eav, w_f ^ w_eav,
                      w_f ^ w_v, w_f ^ w_v ^ w_eav};
    assign w_hlast = (r_h == H_LAST);
    assign w_last  = w_hlast && (r_line == L_LAST);
    assign w_vsync = ((r_line >= L_VS1S) && (r_line <= L_VS1E)) ||
                     ((r_line >= L_F2) && (r_line <= L_VS2E));

    // A pixel is pulled only at C-byte slots of active lines.
    assign w_ready  = w_run && !w_v && w_act && !w_apar;
    assign w_uf_set = w_ready && !pix.in_valid;

    assign pix.in_ready = w_ready;

    always_comb begin
        w_byte = 8'h10;
        if (w_eav || w_sav) begin
            case (w_sidx)
                2'd0:    w_byte = 8'hFF;
                2'd3:    w_byte = w_xy;
                default: w_byte = 8'h00;
            endcase
        end else if (w_act && !w_v) begin
            if (w_apar)
                w_byte = r_yhold;
            else if (pix.in_valid)
                w_byte = clip(pix.in_pixel[15:8]);
            else
                w_byte = 8'h80;
        end else if (w_act) begin
            w_byte = w_apar ? 8'h10 : 8'h80;
        end else begin
            w_byte = w_bpar ? 8'h10 : 8'h80;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_h     <= '0;
            r_line  <= L_ONE;
            r_yhold <= 8'h00;
            r_td    <= 8'h00;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_field <= 1'b0;
            r_sof   <= 1'b0;
            r_uf    <= 1'b0;
        end else begin
            r_uf <= w_uf_set | (r_uf & ~underflow_clr);
            unique case (r_state)
                S_IDLE: begin
                    r_h     <= '0;
                    r_line  <= L_ONE;
                    r_td    <= 8'h10;
                    r_hs    <= 1'b1;
                    r_vs    <= 1'b1;
                    r_field <= 1'b0;
                    r_sof   <= 1'b0;
                    if (en)
                        r_state <= S_RUN;
                end
                S_RUN, S_DRAIN: begin
                    r_td    <= w_byte;
                    r_hs    <= (r_h >= HS_H);
                    r_vs    <= !w_vsync;
                    r_field <= w_f;
                    r_sof   <= (r_h == '0) && (r_line == L_ONE);
                    if (w_ready)
                        r_yhold <= pix.in_valid ?
                                   clip(pix.in_pixel[7:0]) : 8'h10;
                    if (w_hlast) begin
                        r_h    <= '0;
                        r_line <= (r_line == L_LAST) ?
                                  L_ONE : r_line + L_ONE;
                    end else begin
                        r_h <= r_h + HW'(1);
                    end
                    // Without en, finish the frame before going idle.
                    if (en)
                        r_state <= S_RUN;
                    else if (w_last)
                        r_state <= S_IDLE;
                    else
                        r_state <= S_DRAIN;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign td_data   = r_td;
    assign td_hs     = r_hs;
    assign td_vs     = r_vs;
    assign field     = r_field;
    assign sof       = r_sof;
    assign underflow = r_uf;
endmodule
